opc6_busctl: RTL and testbench

Bus controller placed directly downstream of the opc6 CPU core. It consumes the core's address, dout, rnw, vpa, vda and vio bus outputs and returns din and clken. It converts each CPU bus cycle into a req/ack handshake on a separate memory port or I/O port, stalling the core through clken until the access completes. It also contains a 3-source interrupt latch that drives the core's int_b[1:0] and is mapped into I/O space.

---
 rtl/opc6_busctl_if.sv | 13 +
 rtl/opc6_busctl.sv | 163 ++++++++++++++++
 tb/tb_opc6_busctl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/opc6_busctl_if.sv
// Request/acknowledge port used by opc6_busctl for both its memory and its I/O side.
// The controller is the master. The memory or peripheral fabric is the slave.
interface opc6_busctl_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ack;    // single-cycle completion strobe
  logic [15:0] rdata;  // valid while ack=1

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/opc6_busctl.sv
// opc6 bus controller.
// Turns each opc6 CPU bus cycle into a req/ack transfer on the memory port or the I/O port.
// The core is stalled through clken until the transfer completes.
// It also holds a 3-bit interrupt latch that drives int_b and is visible at INTC_ADDR in I/O space.
module opc6_busctl #(
  parameter logic [15:0] INTC_ADDR = 16'hFF00,
  parameter logic [7:0]  TIMEOUT   = 8'd255
) (
  input  logic                 clk,
  input  logic                 reset,
  // CPU side
  input  logic [15:0]          address,
  input  logic [15:0]          dout,
  input  logic                 rnw,
  input  logic                 vpa,
  input  logic                 vda,
  input  logic                 vio,
  output logic [15:0]          din,
  output logic                 clken,
  output logic [1:0]           int_b,
  // downstream ports
  opc6_busctl_if.master        mem,
  opc6_busctl_if.master        io,
  // external interrupt sources, rising-edge sensitive
  input  logic [1:0]           irq
);

  typedef enum logic [1:0] {IDLE, MEM, IO, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic [2:0]  pend;
  logic [1:0]  irq_q;

  logic        access;
  logic        mem_start, io_start, intc_rd, intc_wr;
  logic        port_ack, port_timeout;
  logic        cur_we;
  logic [15:0] port_rdata;
  logic [2:0]  pend_set, pend_clr, pend_nxt;

  assign access     = vpa | vda | vio;
  assign cur_we     = (state == IO) ? io.we    : mem.we;
  assign port_rdata = (state == IO) ? io.rdata : mem.rdata;

  // Next state, one-cycle strobes and clken, decoded from the state and the live CPU bus.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case leaves a latch behind.
    state_nxt    = state;
    mem_start    = 1'b0;
    io_start     = 1'b0;
    intc_rd      = 1'b0;
    intc_wr      = 1'b0;
    port_ack     = 1'b0;
    port_timeout = 1'b0;
    clken        = 1'b0;
    case (state)
      IDLE: begin
        if (!access) begin
          clken = 1'b1;
        end else if (!vio) begin
          mem_start = 1'b1;
          state_nxt = MEM;
        end else if (address == INTC_ADDR) begin
          intc_rd   = rnw;
          intc_wr   = !rnw;
          state_nxt = DONE;
        end else begin
          io_start  = 1'b1;
          state_nxt = IO;
        end
      end
      MEM, IO: begin
        if ((state == MEM) ? mem.ack : io.ack) begin
          port_ack  = 1'b1;
          state_nxt = DONE;
        end else if (wait_cnt == TIMEOUT) begin
          port_timeout = 1'b1;
          state_nxt    = DONE;
        end
      end
      DONE: begin
        clken     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Keep the core's synchronous reset pipeline running while reset is held.
    if (reset) clken = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Port outputs, the wait counter and the read-data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem.req   <= 1'b0;
      mem.we    <= 1'b0;
      mem.addr  <= '0;
      mem.wdata <= '0;
      io.req    <= 1'b0;
      io.we     <= 1'b0;
      io.addr   <= '0;
      io.wdata  <= '0;
      wait_cnt  <= '0;
      din       <= '0;
    end else begin
      if (mem_start) begin
        mem.req   <= 1'b1;
        mem.we    <= !rnw;
        mem.addr  <= address;
        mem.wdata <= dout;
      end
      if (io_start) begin
        io.req   <= 1'b1;
        io.we    <= !rnw;
        io.addr  <= address;
        io.wdata <= dout;
      end
      if (port_ack || port_timeout) begin
        mem.req <= 1'b0;
        io.req  <= 1'b0;
      end

      if (mem_start || io_start)
        wait_cnt <= '0;
      else if ((state == MEM || state == IO) && !port_ack)
        wait_cnt <= wait_cnt + 8'd1;

      // A write leaves din untouched. An aborted access always returns all ones.
      if (port_timeout)
        din <= 16'hFFFF;
      else if (port_ack && !cur_we)
        din <= port_rdata;
      else if (intc_rd)
        din <= {13'b0, pend};
    end
  end

  // A new edge or a timeout wins over a write-one-to-clear in the same cycle.
  assign pend_set = {port_timeout, irq & ~irq_q};
  assign pend_clr = intc_wr ? dout[2:0] : 3'b000;
  assign pend_nxt = (pend & ~pend_clr) | pend_set;

  // Interrupt latch, irq edge detector and registered active-low interrupt outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 2'b00;
      pend  <= 3'b000;
      int_b <= 2'b11;
    end else begin
      irq_q <= irq;
      pend  <= pend_nxt;
      int_b <= {!pend[1], !(pend[0] | pend[2])};
    end
  end

endmodule

// File: tb/tb_opc6_busctl.sv
// Self-checking bench for opc6_busctl.
// Expected stall length, read data and interrupt state come from a transaction-level model.
// The model is the bus-cycle rules applied one access at a time.
module tb_opc6_busctl;

  localparam logic [15:0] INTC_ADDR     = 16'hFF00;
  localparam int          TIMEOUT_WAITS = 256;   // req-high cycles before an abort

  logic        clk;
  logic        reset;
  logic [15:0] address, dout;
  logic        rnw, vpa, vda, vio;
  logic [15:0] din;
  logic        clken;
  logic [1:0]  int_b;
  logic [1:0]  irq;

  opc6_busctl_if mem_if ();
  opc6_busctl_if io_if ();

  opc6_busctl dut (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .dout    (dout),
    .rnw     (rnw),
    .vpa     (vpa),
    .vda     (vda),
    .vio     (vio),
    .din     (din),
    .clken   (clken),
    .int_b   (int_b),
    .mem     (mem_if),
    .io      (io_if),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [15:0] m_din;
  logic [2:0]  m_pend;

  // One CPU bus cycle. delay = cycle (counted from the presenting cycle) in which ack is pulsed.
  // delay < 0 means no ack at all.
  task automatic bus_access(input string name, input bit is_io, input logic [15:0] a,
                            input logic [15:0] wd, input bit rd, input int delay,
                            input logic [15:0] rdata, input logic [1:0] irq_pulse);
    bit          intc, timed_out, done_seen, other_seen, first_req, sel, ack_now;
    int          c, low, req_cycles, exp_low, exp_req;
    logic [15:0] din_seen, exp_din;
    logic [1:0]  exp_int_b;
    logic [2:0]  clr;
    logic [32:0] cap, exp_cap;

    intc      = is_io && (a == INTC_ADDR);
    timed_out = !intc && (delay < 0);
    exp_low   = intc ? 1 : (timed_out ? TIMEOUT_WAITS + 1 : delay + 1);
    exp_req   = intc ? 0 : exp_low - 1;
    if (intc)           exp_din = rd ? {13'b0, m_pend} : m_din;
    else if (timed_out) exp_din = 16'hFFFF;
    else                exp_din = rd ? rdata : m_din;
    clr       = (intc && !rd) ? wd[2:0] : 3'b000;
    m_pend    = (m_pend & ~clr) | {timed_out, irq_pulse};
    m_din     = exp_din;
    exp_int_b = {~m_pend[1], ~(m_pend[0] | m_pend[2])};
    exp_cap   = {!rd, a, wd};

    @(negedge clk);
    address = a; dout = wd; rnw = rd; vio = is_io;
    sel = 1'($urandom_range(0, 1));
    if (is_io) begin vpa = 1'b0; vda = sel; end
    else       begin vpa = sel;  vda = !sel; end
    irq = irq_pulse;
    done_seen = 0; other_seen = 0; first_req = 1;
    c = 0; low = 0; req_cycles = 0; din_seen = '0; cap = '0;

    while (c < 400) begin
      #1;
      if (clken === 1'b1) begin
        done_seen = 1;
        din_seen  = din;
        break;
      end
      low++;
      if ((is_io ? io_if.req : mem_if.req) === 1'b1) begin
        req_cycles++;
        if (first_req) begin
          first_req = 0;
          cap = is_io ? {io_if.we, io_if.addr, io_if.wdata} : {mem_if.we, mem_if.addr, mem_if.wdata};
          n_checks++;
          if (cap !== exp_cap) begin
            n_fail++;
            $display("FAIL %s capture: we/addr/wdata got %h expected %h", name, cap, exp_cap);
          end
        end
      end
      if ((is_io ? mem_if.req : io_if.req) !== 1'b0) other_seen = 1;
      @(negedge clk);
      c++;
      irq = 2'b00;
      ack_now = (c == delay);
      if (is_io) begin
        io_if.ack   = ack_now;
        io_if.rdata = ack_now ? rdata : ~rdata;
      end else begin
        mem_if.ack   = ack_now;
        mem_if.rdata = ack_now ? rdata : ~rdata;
      end
    end

    n_checks++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL %s completion: no clken pulse within 400 cycles, expected after %0d", name, exp_low);
    end
    n_checks++;
    if (low != exp_low) begin
      n_fail++;
      $display("FAIL %s stall: clken low for %0d cycles, expected %0d", name, low, exp_low);
    end
    n_checks++;
    if (din_seen !== exp_din) begin
      n_fail++;
      $display("FAIL %s din: got %h expected %h", name, din_seen, exp_din);
    end
    n_checks++;
    if (req_cycles != exp_req) begin
      n_fail++;
      $display("FAIL %s req width: high %0d cycles, expected %0d", name, req_cycles, exp_req);
    end
    n_checks++;
    if (other_seen) begin
      n_fail++;
      $display("FAIL %s wrong port: other req went high, expected it to stay 0", name);
    end

    @(negedge clk);
    vpa = 1'b0; vda = 1'b0; vio = 1'b0;
    mem_if.ack = 1'b0; io_if.ack = 1'b0; irq = 2'b00;
    #1;
    n_checks++;
    if (int_b !== exp_int_b) begin
      n_fail++;
      $display("FAIL %s int_b: got %b expected %b", name, int_b, exp_int_b);
    end
    n_checks++;
    if (clken !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle clken: got %b expected 1", name, clken);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    address = 16'h0000; dout = 16'h0000; rnw = 1'b1;
    vpa = 1'b0; vda = 1'b1; vio = 1'b0; irq = 2'b00;
    mem_if.ack = 1'b0; mem_if.rdata = 16'h0000;
    io_if.ack  = 1'b0; io_if.rdata  = 16'h0000;
    m_din = 16'h0000; m_pend = 3'b000;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if ({clken, int_b, mem_if.req, io_if.req} !== 5'b11100) begin
      n_fail++;
      $display("FAIL reset outputs: clken/int_b/mem_req/io_req got %b expected 11100",
               {clken, int_b, mem_if.req, io_if.req});
    end
    n_checks++;
    if (din !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset din: got %h expected 0000", din);
    end
    vda = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (clken !== 1'b1) begin
      n_fail++;
      $display("FAIL idle clken after reset: got %b expected 1", clken);
    end
  endtask

  task automatic test_fetch();
    bus_access("fetch", 1'b0, 16'h0000, 16'h0000, 1'b1, 2, 16'h1234, 2'b00);
  endtask

  task automatic test_mem_write();
    bus_access("mem_write", 1'b0, 16'h0100, 16'hBEEF, 1'b0, 5, 16'h0000, 2'b00);
  endtask

  task automatic test_io_read();
    bus_access("io_read", 1'b1, 16'h0010, 16'h0000, 1'b1, 3, 16'h00A5, 2'b00);
  endtask

  task automatic test_timeout();
    bus_access("timeout_read", 1'b0, 16'h2000, 16'h0000, 1'b1, -1, 16'h0000, 2'b00);
    n_checks++;
    if (int_b[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout int_b0: got %b expected 0", int_b[0]);
    end
    bus_access("intc_clear_timeout", 1'b1, INTC_ADDR, 16'h0004, 1'b0, 1, 16'h0000, 2'b00);
  endtask

  task automatic test_irq();
    @(negedge clk);
    irq = 2'b10;
    @(negedge clk);
    irq = 2'b00;
    #1;
    n_checks++;
    if (int_b[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL irq1 one cycle: int_b1 got %b expected 1", int_b[1]);
    end
    m_pend[1] = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (int_b[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL irq1 two cycles: int_b1 got %b expected 0", int_b[1]);
    end
    bus_access("intc_read", 1'b1, INTC_ADDR, 16'h0000, 1'b1, 1, 16'hDEAD, 2'b00);
    n_checks++;
    if (din !== 16'h0002) begin
      n_fail++;
      $display("FAIL intc_read value: got %h expected 0002", din);
    end
    bus_access("w1c_vs_edge", 1'b1, INTC_ADDR, 16'h0002, 1'b0, 1, 16'h0000, 2'b10);
    bus_access("w1c_clear", 1'b1, INTC_ADDR, 16'h0002, 1'b0, 1, 16'h0000, 2'b00);
  endtask

  task automatic test_random();
    int          kind, delay;
    bit          is_io, rd;
    logic [15:0] a, wd, rdata;
    logic [1:0]  pulse;
    for (int i = 0; i < 40; i++) begin
      kind  = $urandom_range(0, 2);
      is_io = (kind != 0);
      a     = 16'($urandom);
      if (kind == 2)                        a = INTC_ADDR;
      else if (kind == 1 && a == INTC_ADDR) a = a ^ 16'h0001;
      wd    = 16'($urandom);
      rd    = 1'($urandom_range(0, 1));
      delay = $urandom_range(1, 6);
      rdata = 16'($urandom);
      pulse = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus_access($sformatf("random_%0d", i), is_io, a, wd, rd, delay, rdata, pulse);
    end
    // a memory cycle at the INTC address must still go to the memory port
    bus_access("mem_at_intc_addr", 1'b0, INTC_ADDR, 16'h0000, 1'b1, 1, 16'h7E57, 2'b00);
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    address = 16'h3000; rnw = 1'b1; vpa = 1'b0; vda = 1'b1; vio = 1'b0;
    mem_if.ack = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (mem_if.req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_access req: got %b expected 1", mem_if.req);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_if.req, clken} !== 2'b01) begin
      n_fail++;
      $display("FAIL async reset: mem_req/clken got %b expected 01", {mem_if.req, clken});
    end
    vda = 1'b0;
    m_din = 16'h0000; m_pend = 3'b000;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mem_if.ack = 1'b1; mem_if.rdata = 16'h5A5A;
    @(negedge clk);
    mem_if.ack = 1'b0;
    #1;
    n_checks++;
    if ({mem_if.req, clken, din} !== {1'b0, 1'b1, m_din}) begin
      n_fail++;
      $display("FAIL stale ack: mem_req/clken/din got %b/%b/%h expected 0/1/%h",
               mem_if.req, clken, din, m_din);
    end
    bus_access("after_reset_read", 1'b0, 16'h3000, 16'h0000, 1'b1, 1, 16'hC0DE, 2'b00);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_mem_write();
    test_io_read();
    test_timeout();
    test_irq();
    test_random();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

endmodule
